// File: rtl/fib_if.sv
// Request/acknowledge link between the Fibonacci requester (master) and the engine (slave).
interface fib_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 90
);
  logic             req;
  logic [N_IN-1:0]  n;
  logic             ack;
  logic [N_OUT-1:0] result;

  modport master (output req, output n, input ack, input result);
  modport slave  (input req, input n, output ack, output result);
endinterface

// File: rtl/fib_requester.sv
// Sweeps n_first..n_last through the Fibonacci engine, strobes each result,
// checks the recurrence on consecutive results and bounds every request with a timeout.
module fib_requester #(
  parameter int N_IN    = 7,
  parameter int N_OUT   = 90,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [N_IN-1:0]  n_first_i,
  input  logic [N_IN-1:0]  n_last_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic             timeout_err_o,
  output logic             seq_err_o,
  output logic             res_valid_o,
  output logic [N_IN-1:0]  res_n_o,
  output logic [N_OUT-1:0] res_value_o,
  fib_if.master            eng
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_CLR = 3'd1,
    S_REQ_ACK = 3'd2,
    S_REL     = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t           state_q;
  logic [N_IN-1:0]  cur_q;
  logic [N_IN-1:0]  last_q;
  logic [N_IN-1:0]  n_q;
  logic             req_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_err_q;
  logic             timeout_err_q;
  logic             seq_err_q;
  logic             res_valid_q;
  logic [N_IN-1:0]  res_n_q;
  logic [N_OUT-1:0] res_value_q;
  logic [N_OUT-1:0] p1_q;
  logic [N_OUT-1:0] p2_q;
  logic [1:0]       hist_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [3:0]       gap_q;

  logic [N_OUT-1:0] sum_d;
  logic [N_IN-1:0]  cur_inc_d;
  logic [TO_W-1:0]  to_inc_d;
  logic             range_bad_d;
  logic             seq_bad_d;

  // Next-value helpers: recurrence sum, index increment and range validity
  always_comb begin
    sum_d       = p1_q + p2_q;
    cur_inc_d   = cur_q + {{(N_IN-1){1'b0}}, 1'b1};
    to_inc_d    = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    range_bad_d = (n_first_i == {N_IN{1'b0}}) || (n_first_i > n_last_i);
    if (hist_q == 2'd2) begin
      seq_bad_d = (eng.result != sum_d);
    end else begin
      seq_bad_d = 1'b0;
    end
  end

  // Sweep controller with registered handshake, status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      last_q        <= '0;
      n_q           <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      seq_err_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_n_q       <= '0;
      res_value_q   <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      hist_q        <= 2'd0;
      to_cnt_q      <= '0;
      gap_q         <= 4'd0;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (range_bad_d) begin
              cfg_err_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              last_q        <= n_last_i;
              cur_q         <= n_first_i;
              n_q           <= n_first_i;
              cfg_err_q     <= 1'b0;
              timeout_err_q <= 1'b0;
              seq_err_q     <= 1'b0;
              hist_q        <= 2'd0;
              busy_q        <= 1'b1;
              req_q         <= 1'b1;
              to_cnt_q      <= '0;
              state_q       <= S_REQ_CLR;
            end
          end
        end
        S_REQ_CLR, S_REQ_ACK: begin
          // REQ_CLR only waits for the stale ack of the previous transfer to fall
          if ((state_q == S_REQ_ACK) && eng.ack) begin
            res_valid_q <= 1'b1;
            res_n_q     <= cur_q;
            res_value_q <= eng.result;
            seq_err_q   <= seq_err_q | seq_bad_d;
            p2_q        <= p1_q;
            p1_q        <= eng.result;
            if (hist_q != 2'd2) begin
              hist_q <= hist_q + 2'd1;
            end
            req_q   <= 1'b0;
            gap_q   <= 4'd0;
            state_q <= S_REL;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            req_q         <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= S_FIN;
          end else begin
            to_cnt_q <= to_inc_d;
            if ((state_q == S_REQ_CLR) && !eng.ack) begin
              state_q <= S_REQ_ACK;
            end
          end
        end
        S_REL: begin
          if (gap_q == 4'(GAP - 1)) begin
            if (cur_q == last_q) begin
              state_q <= S_FIN;
            end else begin
              cur_q    <= cur_inc_d;
              n_q      <= cur_inc_d;
              req_q    <= 1'b1;
              to_cnt_q <= '0;
              state_q  <= S_REQ_CLR;
            end
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign eng.req       = req_q;
  assign eng.n         = n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;
  assign timeout_err_o = timeout_err_q;
  assign seq_err_o     = seq_err_q;
  assign res_valid_o   = res_valid_q;
  assign res_n_o       = res_n_q;
  assign res_value_o   = res_value_q;

endmodule

// File: tb/tb_fib_requester.sv
// Bench for fib_requester: behavioural engine stub, table of sweeps, hand-written
// corner sequences and randomized sweeps checked against a Fibonacci reference.
module tb_fib_requester;

  localparam int N_IN    = 7;
  localparam int N_OUT   = 90;
  localparam int TIMEOUT = 20;
  localparam int GAP     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_IN-1:0]  n_first;
  logic [N_IN-1:0]  n_last;
  logic             busy, done, cfg_err, timeout_err, seq_err, res_valid;
  logic [N_IN-1:0]  res_n;
  logic [N_OUT-1:0] res_value;

  fib_if #(.N_IN(N_IN), .N_OUT(N_OUT)) eng_if ();

  fib_requester #(.N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start_i(start), .n_first_i(n_first), .n_last_i(n_last),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err), .timeout_err_o(timeout_err),
    .seq_err_o(seq_err), .res_valid_o(res_valid), .res_n_o(res_n),
    .res_value_o(res_value), .eng(eng_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // engine mode: 0 = true Fibonacci, 1 = never acknowledges, 2 = returns 1,1,3 for n=1..3
  int eng_mode = 0;
  int eng_lo = 0;
  int eng_hi = 4;
  // sticky flag model
  bit m_cfg, m_to, m_seq;

  function automatic logic [N_OUT-1:0] fib(input int k);
    logic [N_OUT-1:0] a, b, t;
    a = '0;
    b = 90'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [N_OUT-1:0] stub_value(input int mode, input int k);
    if (mode == 2 && k == 3) return 90'd3;
    return fib(k);
  endfunction

  // Engine stub: holds ack from one transfer until it sees the next req
  int              e_st, e_cnt;
  logic [N_IN-1:0] e_n;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_if.ack    <= 1'b0;
      eng_if.result <= '0;
      e_st <= 0;
      e_cnt <= 0;
      e_n <= '0;
    end else begin
      case (e_st)
        0: if (eng_if.req) begin
             e_n <= eng_if.n;
             e_cnt <= $urandom_range(eng_hi, eng_lo);
             e_st <= 1;
           end
        1: if (!eng_if.req) e_st <= 0;
           else if (eng_mode != 1) begin
             if (e_cnt == 0) begin
               eng_if.ack    <= 1'b1;
               eng_if.result <= stub_value(eng_mode, int'(e_n));
               e_st <= 2;
             end else e_cnt <= e_cnt - 1;
           end
        2: if (!eng_if.req) e_st <= 3;
        3: if (eng_if.req) begin
             eng_if.ack <= 1'b0;
             e_st <= 0;
           end
        default: e_st <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [N_IN-1:0] nf, input logic [N_IN-1:0] nl,
                           input int mode, input bit exp_cfg, input bit exp_to);
    logic [N_OUT-1:0] ev[$];
    logic [N_IN-1:0]  en[$];
    bit cfg_bad, saw_done;
    int req_hi, busy_hi, got, exp_cnt;
    cfg_bad = (nf == 0) || (nf > nl);
    eng_mode = mode;
    if (cfg_bad) begin
      m_cfg = 1'b1;
    end else begin
      m_cfg = 1'b0; m_to = 1'b0; m_seq = 1'b0;
      if (mode == 1) m_to = 1'b1;
      else for (int i = int'(nf); i <= int'(nl); i++) begin
        en.push_back(N_IN'(i));
        ev.push_back(stub_value(mode, i));
      end
      for (int k = 2; k < ev.size(); k++)
        if (ev[k] != ev[k-1] + ev[k-2]) m_seq = 1'b1;
    end
    exp_cnt = en.size();
    chk("tbl_cfg_expect", m_cfg, exp_cfg);
    chk("tbl_to_expect", m_to, exp_to);
    n_first = nf; n_last = nl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 0; req_hi = 0; busy_hi = 0; got = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (eng_if.req) req_hi++;
      if (busy) busy_hi++;
      if (res_valid) begin
        got++;
        if (en.size() > 0) begin
          chk("res_n", res_n, en.pop_front());
          chk("res_value", res_value, ev.pop_front());
        end
      end
      if (done) begin
        saw_done = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", saw_done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("cfg_err", cfg_err, m_cfg);
    chk("timeout_err", timeout_err, m_to);
    chk("seq_err", seq_err, m_seq);
    chk("res_count", got, exp_cnt);
    if (cfg_bad) begin
      chk("req_never", req_hi, 0);
      chk("busy_never", busy_hi, 0);
    end
    if (mode == 1 && !cfg_bad) chk("timeout_req_len", req_hi, TIMEOUT);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  typedef struct {
    logic [N_IN-1:0] nf;
    logic [N_IN-1:0] nl;
    int              mode;
    bit              stale;
    bit              exp_cfg;
    bit              exp_to;
  } vec_t;

  vec_t tbl[9];
  int   hits;
  logic [N_IN-1:0] rf, rl;

  initial begin
    tbl[0] = '{7'd1,   7'd10,  0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{7'd5,   7'd7,   0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{7'd0,   7'd4,   0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{7'd8,   7'd3,   0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{7'd2,   7'd4,   0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{7'd3,   7'd5,   1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{7'd1,   7'd3,   2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{7'd125, 7'd127, 0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{7'd1,   7'd1,   0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; n_first = '0; n_last = '0;
    m_cfg = 0; m_to = 0; m_seq = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_errs", {cfg_err, timeout_err, seq_err}, 3'b000);
    chk("rst_req", eng_if.req, 1'b0);
    chk("rst_n", eng_if.n, 7'd0);
    chk("rst_res", {res_valid, res_n, res_value}, 98'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].stale) chk("ack_stale_before_start", eng_if.ack, 1'b1);
      run_sweep(tbl[i].nf, tbl[i].nl, tbl[i].mode, tbl[i].exp_cfg, tbl[i].exp_to);
    end

    // asynchronous reset while the n=6 request waits for its ack
    eng_mode = 0; eng_lo = 6; eng_hi = 6;
    n_first = 7'd4; n_last = 7'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hits = 0;
    for (int c = 0; c < 500 && hits < 2; c++) begin
      @(negedge clk);
      if (eng_if.req && eng_if.n == 7'd6 && !eng_if.ack) hits++;
      else hits = 0;
    end
    chk("reached_req_ack_n6", hits, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", eng_if.req, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done_valid", {done, res_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    m_cfg = 0; m_to = 0; m_seq = 0;
    eng_lo = 0; eng_hi = 4;
    @(negedge clk);
    run_sweep(7'd1, 7'd10, 0, 1'b0, 1'b0);

    // randomized sweeps, some with a rejected range
    for (int r = 0; r < 8; r++) begin
      rf = N_IN'($urandom_range(127, 1));
      rl = N_IN'((int'(rf) + $urandom_range(6, 0) > 127) ? 127 : int'(rf) + $urandom_range(6, 0));
      if ($urandom_range(3, 0) == 0 && rf > 1) rl = rf - 7'd1;
      run_sweep(rf, rl, 0, (rf > rl), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_requester.md
Name: fib_requester

Overview:
- Initiator for the Fibonacci req/ack responder: sweeps the index range n_first..n_last and issues one request per index.
- Captures each result and presents it on a one-cycle result strobe.
- Checks consecutive results against the Fibonacci recurrence and guards every request with a timeout.
- Sits between the host control logic and the fib engine. Its req/n ports connect directly to the engine's req/n, and its ack/result inputs connect directly to the engine's ack/result.

Parameters:
- N_IN, 7: width of the index n.
- N_OUT, 90: width of the result.
- TIMEOUT, 1023: maximum cycles from req rise to ack high before aborting.
- GAP, 2: cycles req is held low between consecutive requests (legal range 1..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle sweep launch; ignored unless idle.
- n_first  input  N_IN  first index, sampled on accepted start.
- n_last  input  N_IN  last index, sampled on accepted start.
- busy  output  1  high from accepted start until sweep end.
- done  output  1  one-cycle pulse at sweep end (normal, timeout or cfg error).
- cfg_err  output  1  sticky; set when start is rejected for bad range.
- timeout_err  output  1  sticky; set on request timeout.
- seq_err  output  1  sticky; set on recurrence mismatch.
- req  output  1  request to engine.
- n  output  N_IN  index to engine; stable whenever req is high.
- ack  input  1  engine acknowledge.
- result  input  N_OUT  engine result; valid while ack is high.
- res_valid  output  1  one-cycle strobe per captured result.
- res_n  output  N_IN  index of the strobed result.
- res_value  output  N_OUT  strobed result value.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and counters and history registers are 0.
- Sticky error flags clear only on rst or on the next accepted start.
- IDLE:
  - start with n_first==0 or n_first>n_last: set cfg_err, pulse done next cycle, stay IDLE, never assert busy or req.
  - Otherwise: latch the range, set cur=n_first, clear sticky flags, assert busy, go to REQ_CLR.
- REQ_CLR:
  - Drive req=1, n=cur, and start the timeout counter at 0.
  - The engine holds ack high from the previous transfer until it sees the new req, so wait here until ack==0, then go to REQ_ACK.
  - On the first request after reset, ack is already 0, so REQ_ACK is reached one cycle later.
- REQ_ACK:
  - Keep req=1.
  - On ack==1: capture result into res_value, set res_n=cur, pulse res_valid for exactly one cycle, drop req, go to REL.
- Timeout:
  - The counter increments every cycle in REQ_CLR and REQ_ACK.
  - When it reaches TIMEOUT with no capture, drop req, set timeout_err, go to FIN. No res_valid for that index.
- REL:
  - req=0 for exactly GAP cycles.
  - Then, if cur==n_last go to FIN; otherwise cur=cur+1 and go to REQ_CLR.
  - Increment uses N_IN bits. n_last at all-ones terminates through the cur==n_last compare, so there is no wrap.
- FIN: pulse done for one cycle, deassert busy, go to IDLE.
- Recurrence check:
  - Keep the previous two captured values p1, p2 and a valid count (0..2) within the current sweep.
  - On each capture with count==2: if result != (p1+p2) mod 2^N_OUT, set seq_err. The sweep continues.
  - Then shift: p2=p1, p1=result, count saturates at 2.
- Outputs:
  - req is registered and never toggles more than once per cycle.
  - n changes only while req==0.
  - start while busy is ignored.
- Asynchronous rst mid-sweep: req, busy and all outputs go to 0 immediately. The engine is reset by the same system reset.
- Total latency per index with the standard engine: roughly n+4+GAP cycles from req rise to next req rise.

Test Plan:
- Reset, then start with n_first=1, n_last=10 → res_valid pulses 10 times with (res_n,res_value) = (1,1) (2,1) (3,2) (4,3) (5,5) (6,8) (7,13) (8,21) (9,34) (10,55); one done pulse; seq_err=0; busy low after done.
- Back-to-back sweep 5..7 immediately after a sweep ends (ack still stale high) → req is held until ack falls, then rises; results are 5, 8, 13 with no duplicate or stale capture.
- start with n_first=0, or with n_first=8 and n_last=3 → cfg_err=1, done pulses once, req never rises, busy stays 0.
- Stub responder that never asserts ack, TIMEOUT=20 → req drops exactly 20 cycles after rising; timeout_err=1; done pulses; no res_valid.
- Stub responder returning 1, 1, 3 for n=1..3 → seq_err set on the third capture; sweep still completes with done.
- Assert rst during REQ_ACK of n=6 → req, busy, done and res_valid go to 0 asynchronously; a new start after release of rst runs a clean sweep.
